// File: rtl/seq_1011_pkg.sv
// ---------------------------------------------------------------------------
// seq_1011_pkg
//   Shared definitions for the 1011-framed serial link.
//   The transmitter (seq_gen_1011_tx) and the receiver (seq_det_1011) both use
//   this package, so the marker and the stuffing trigger are defined once here.
//
//   MARKER_W   : number of marker bits at the start of every frame
//   MARKER     : the frame marker, sent MSB first
//   STUFF_TRIG : the last three line bits that force a stuff bit when the next
//                payload bit would be a 1 (101 + 1 would recreate the marker)
//   tx_state_t : transmitter FSM states
// ---------------------------------------------------------------------------
package seq_1011_pkg;

  localparam int                  MARKER_W   = 4;
  localparam logic [MARKER_W-1:0] MARKER     = 4'b1011;
  localparam logic [2:0]          STUFF_TRIG = 3'b101;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SYNC  = 2'd1,
    DATA  = 2'd2,
    STUFF = 2'd3
  } tx_state_t;

endpackage

// File: rtl/seq_gen_1011_tx_if.sv
// ---------------------------------------------------------------------------
// seq_gen_1011_tx_if
//   Bundles the parallel input handshake and the serial line of the 1011
//   transmitter.
//
//   in_data     : payload word, sampled on a handshake
//   in_valid    : in_data is valid
//   in_ready    : transmitter can accept a word
//   ser_out     : serial line bit
//   ser_valid   : ser_out carries a frame bit this cycle
//   frame_start : pulses with the first marker bit
//   stuffed     : the current ser_out bit is a stuff bit
//
//   master : the word producer / line observer
//   slave  : the transmitter itself
// ---------------------------------------------------------------------------
interface seq_gen_1011_tx_if #(
  parameter int DATA_W = 8
);

  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic              ser_out;
  logic              ser_valid;
  logic              frame_start;
  logic              stuffed;

  modport master (
    output in_data,
    output in_valid,
    input  in_ready,
    input  ser_out,
    input  ser_valid,
    input  frame_start,
    input  stuffed
  );

  modport slave (
    input  in_data,
    input  in_valid,
    output in_ready,
    output ser_out,
    output ser_valid,
    output frame_start,
    output stuffed
  );

endinterface

// File: rtl/seq_stuff_chk.sv
// ---------------------------------------------------------------------------
// seq_stuff_chk
//   Line-bit history and stuff decision for the 1011 transmitter.
//   hist holds the last three emitted line bits, newest in the LSB, and is
//   never cleared between frames.
//
//   clk        : clock, rising edge
//   rst_n      : asynchronous active-low reset (hist -> 000)
//   shift_en   : a line bit is being emitted on this edge
//   shift_bit  : value of that line bit
//   next_bit   : payload bit that would be emitted on the following edge
//   stuff_need : the following edge must emit a stuff bit instead of next_bit
// ---------------------------------------------------------------------------
module seq_stuff_chk
  import seq_1011_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic shift_en,
  input  logic shift_bit,
  input  logic next_bit,
  output logic stuff_need
);

  logic [2:0] hist;
  logic [2:0] hist_next;

  always_comb begin
    hist_next = hist;
    if (shift_en) begin
      hist_next = {hist[1:0], shift_bit};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist <= 3'b000;
    end else begin
      hist <= hist_next;
    end
  end

  // The decision is about the bit after the one going out now, so compare
  // against the history as it will be once the current bit is on the line.
  assign stuff_need = (hist_next == STUFF_TRIG) && next_bit;

endmodule

// File: rtl/seq_gen_1011_tx.sv
// ---------------------------------------------------------------------------
// seq_gen_1011_tx
//   Transmit side of the 1011-framed serial link. A word accepted over the
//   valid/ready handshake is sent as the marker 1011 followed by the payload,
//   MSB first, one bit per clock. With STUFF_EN set, a 0 is inserted before
//   any payload 1 whose three preceding line bits are 101, so the receiver can
//   only ever see 1011 at the start of a frame.
//
//   Parameters
//     DATA_W   : payload width in bits (>= 1)
//     STUFF_EN : 1 inserts stuff bits, 0 sends the payload raw
//   Ports
//     clk   : clock, rising edge
//     rst_n : asynchronous active-low reset; aborts a frame immediately
//     bus   : slave side of seq_gen_1011_tx_if (handshake + serial line)
//
//   Timing: the FSM state names the bit that is registered onto the line at
//   the next edge, so the line lags the state by one clock. A handshake at
//   edge N moves IDLE->SYNC, and the first marker bit appears after edge N+1.
// ---------------------------------------------------------------------------
module seq_gen_1011_tx
  import seq_1011_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter bit STUFF_EN = 1'b1
) (
  input logic              clk,
  input logic              rst_n,
  seq_gen_1011_tx_if.slave bus
);

  localparam int CNT_W  = $clog2(DATA_W + 1);
  localparam int MIDX_W = $clog2(MARKER_W);

  // FSM and datapath state
  tx_state_t         state;
  tx_state_t         state_next;
  logic [CNT_W-1:0]  bit_cnt;
  logic [CNT_W-1:0]  bit_cnt_next;
  logic [MIDX_W-1:0] mark_idx;
  logic [MIDX_W-1:0] mark_idx_next;
  logic [DATA_W-1:0] shreg;
  logic [DATA_W-1:0] shreg_next;

  // Registered outputs
  logic in_ready_reg;
  logic in_ready_next;
  logic ser_out_reg;
  logic ser_out_next;
  logic ser_valid_reg;
  logic ser_valid_next;
  logic frame_start_reg;
  logic frame_start_next;
  logic stuffed_reg;
  logic stuffed_next;

  // Bit emitted on the coming edge and the stuff look-ahead
  logic              emit_valid;
  logic              emit_bit;
  logic [MARKER_W-1:0] marker_sh;
  logic [DATA_W-1:0] shreg_shift;
  logic              next_bit;
  logic              stuff_need;
  logic              stuff_now;
  logic              last_bit;

  // -------------------------------------------------------------------------
  // Emitted bit for the current state
  // -------------------------------------------------------------------------
  always_comb begin
    emit_valid = 1'b0;
    emit_bit   = 1'b0;
    marker_sh  = MARKER << mark_idx;
    unique case (state)
      SYNC: begin
        emit_valid = 1'b1;
        emit_bit   = marker_sh[MARKER_W-1];
      end
      DATA: begin
        emit_valid = 1'b1;
        emit_bit   = shreg[DATA_W-1];
      end
      STUFF: begin
        emit_valid = 1'b1;
        emit_bit   = 1'b0;
      end
      default: begin
        emit_valid = 1'b0;
        emit_bit   = 1'b0;
      end
    endcase
  end

  // The payload bit that would follow the current emission: in DATA the MSB
  // is being consumed now, elsewhere the MSB is still pending.
  assign shreg_shift = shreg << 1;
  assign next_bit    = (state == DATA) ? shreg_shift[DATA_W-1] : shreg[DATA_W-1];
  assign last_bit    = (bit_cnt == CNT_W'(DATA_W - 1));
  assign stuff_now   = STUFF_EN && stuff_need;

  seq_stuff_chk u_stuff_chk (
    .clk        (clk),
    .rst_n      (rst_n),
    .shift_en   (emit_valid),
    .shift_bit  (emit_bit),
    .next_bit   (next_bit),
    .stuff_need (stuff_need)
  );

  // -------------------------------------------------------------------------
  // State register (also holds the datapath and output registers)
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      bit_cnt         <= '0;
      mark_idx        <= '0;
      shreg           <= '0;
      in_ready_reg    <= 1'b0;
      ser_out_reg     <= 1'b0;
      ser_valid_reg   <= 1'b0;
      frame_start_reg <= 1'b0;
      stuffed_reg     <= 1'b0;
    end else begin
      state           <= state_next;
      bit_cnt         <= bit_cnt_next;
      mark_idx        <= mark_idx_next;
      shreg           <= shreg_next;
      in_ready_reg    <= in_ready_next;
      ser_out_reg     <= ser_out_next;
      ser_valid_reg   <= ser_valid_next;
      frame_start_reg <= frame_start_next;
      stuffed_reg     <= stuffed_next;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_next    = state;
    bit_cnt_next  = bit_cnt;
    mark_idx_next = mark_idx;
    shreg_next    = shreg;
    in_ready_next = in_ready_reg;
    unique case (state)
      IDLE: begin
        // in_ready rises one clock after entering IDLE (after reset or after
        // the last payload bit), which guarantees an idle gap on the line.
        if (!in_ready_reg) begin
          in_ready_next = 1'b1;
        end else if (bus.in_valid) begin
          in_ready_next = 1'b0;
          shreg_next    = bus.in_data;
          bit_cnt_next  = '0;
          mark_idx_next = '0;
          state_next    = SYNC;
        end
      end
      SYNC: begin
        if (mark_idx == MIDX_W'(MARKER_W - 1)) begin
          mark_idx_next = '0;
          state_next    = stuff_now ? STUFF : DATA;
        end else begin
          mark_idx_next = mark_idx + 1'b1;
        end
      end
      DATA: begin
        shreg_next   = shreg_shift;
        bit_cnt_next = bit_cnt + 1'b1;
        if (last_bit) begin
          state_next = IDLE;
        end else begin
          state_next = stuff_now ? STUFF : DATA;
        end
      end
      STUFF: begin
        // The pending payload bit stays in the shift register.
        state_next = stuff_now ? STUFF : DATA;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Output logic (values registered on the coming edge)
  // -------------------------------------------------------------------------
  always_comb begin
    ser_out_next     = emit_valid & emit_bit;
    ser_valid_next   = emit_valid;
    frame_start_next = (state == SYNC) && (mark_idx == '0);
    stuffed_next     = (state == STUFF);
  end

  assign bus.in_ready    = in_ready_reg;
  assign bus.ser_out     = ser_out_reg;
  assign bus.ser_valid   = ser_valid_reg;
  assign bus.frame_start = frame_start_reg;
  assign bus.stuffed     = stuffed_reg;

endmodule
